// File: rtl/fsm_seq_generator_pkg.sv
// Shared definitions for the serial pattern transmitter: state encoding and
// counter sizing helpers.
package fsm_seq_generator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        GAP   = 2'b10,
        DONE  = 2'b11
    } state_t;

    // A zero- or one-cycle gap still needs a one-bit counter so that ports stay legal.
    function automatic int gap_w(input int gap_cyc);
        return (gap_cyc > 1) ? $clog2(gap_cyc) : 1;
    endfunction

endpackage

// File: rtl/fsm_seq_generator_shift.sv
// Frame shift register: parallel load has priority over shift; MSB drives the line.
module fsm_seq_generator_shift #(
    parameter int PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [PAT_W-1:0] din,
    output logic             msb
);

    logic [PAT_W-1:0] shift_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
        end else if (load) begin
            shift_q <= din;
        end else if (shift_en) begin
            shift_q <= {shift_q[PAT_W-2:0], 1'b0};
        end
    end

    assign msb = shift_q[PAT_W-1];

endmodule

// File: rtl/fsm_seq_generator.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeat_n
// times with GAP_CYC idle cycles between frames, then pulses done.
//
//   state | meaning
//   IDLE  | waiting for start; pattern and repeat_n captured on accept
//   SHIFT | one pattern bit on dout per cycle
//   GAP   | idle line between frames, GAP_CYC cycles
//   DONE  | one-cycle done pulse, start ignored
module fsm_seq_generator
    import fsm_seq_generator_pkg::*;
#(
    parameter int PAT_W   = 8,
    parameter int CNT_W   = 4,
    parameter int GAP_CYC = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             dout,
    output logic             dout_vld,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    localparam int BIT_W = $clog2(PAT_W) + 1;
    localparam int GAP_W = gap_w(GAP_CYC);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t             state_q;
    state_t             state_d;
    logic [PAT_W-1:0]   pat_q;
    logic [BIT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   frm_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               bit_last;
    logic               frm_last;
    logic               gap_last;
    logic               load;
    logic               shift_en;
    logic [PAT_W-1:0]   load_val;
    logic               msb;

    assign bit_last = (bit_cnt == BIT_W'(PAT_W - 1));
    assign frm_last = (frm_cnt == CNT_W'(1));
    assign gap_last = (gap_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT: begin
                if (bit_last) begin
                    if (frm_last)         state_d = DONE;
                    else if (GAP_CYC > 0) state_d = GAP;
                    else                  state_d = SHIFT;
                end
            end
            GAP:     if (gap_last) state_d = SHIFT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dout     = 1'b0;
        dout_vld = 1'b0;
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        state    = state_q;
        if (state_q == SHIFT) begin
            dout     = msb;
            dout_vld = 1'b1;
        end
    end

    // Frame count is a down-counter; repeat_n of zero is promoted to one frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q   <= '0;
            bit_cnt <= '0;
            frm_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        pat_q   <= pattern;
                        frm_cnt <= (repeat_n == '0) ? CNT_W'(1) : repeat_n;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (bit_last) begin
                        bit_cnt <= '0;
                        gap_cnt <= GAP_LOAD;
                        if (!frm_last) frm_cnt <= frm_cnt - CNT_W'(1);
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                GAP: begin
                    if (!gap_last) gap_cnt <= gap_cnt - GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        load_val = (state_q == IDLE) ? pattern : pat_q;
        load     = ((state_q == IDLE) && start)
                 || ((state_q == SHIFT) && bit_last && !frm_last && (GAP_CYC == 0))
                 || ((state_q == GAP) && gap_last);
        shift_en = (state_q == SHIFT) && !load;
    end

    fsm_seq_generator_shift #(
        .PAT_W (PAT_W)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .din      (load_val),
        .msb      (msb)
    );

endmodule

// File: tb/tb_fsm_seq_generator.sv
// Directed bench for the serial pattern transmitter (PAT_W=8, CNT_W=4, GAP_CYC=2).
module tb_fsm_seq_generator;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] repeat_n;
    logic       dout;
    logic       dout_vld;
    logic       busy;
    logic       done;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    fsm_seq_generator #(
        .PAT_W   (8),
        .CNT_W   (4),
        .GAP_CYC (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pattern  (pattern),
        .repeat_n (repeat_n),
        .dout     (dout),
        .dout_vld (dout_vld),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " state"},    32'(state),    32'd0);
        check({tag, " dout"},     32'(dout),     32'd0);
        check({tag, " dout_vld"}, 32'(dout_vld), 32'd0);
        check({tag, " busy"},     32'(busy),     32'd0);
        check({tag, " done"},     32'(done),     32'd0);
    endtask

    // Runs one job and checks every cycle from the first bit to the done cycle.
    // hold keeps start high throughout; intf_at (>0) pulses start with a new
    // pattern and repeat count at that cycle of the job.
    task automatic do_job(input string name, input logic [7:0] p, input logic [3:0] rn,
                          input bit hold, input int intf_at);
        int r;
        int total;
        int idx;
        int pos;
        logic       e_dout;
        logic       e_vld;
        logic       e_done;
        logic [1:0] e_state;
        r     = (rn == 4'd0) ? 1 : int'(rn);
        total = r * 8 + (r - 1) * 2 + 1;
        @(negedge clk);
        check({name, " pre state"}, 32'(state), 32'd0);
        check({name, " pre busy"},  32'(busy),  32'd0);
        start    = 1'b1;
        pattern  = p;
        repeat_n = rn;
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            idx = (c - 1) / 10;
            pos = (c - 1) % 10;
            if (c == total) begin
                e_dout = 1'b0; e_vld = 1'b0; e_done = 1'b1; e_state = 2'b11;
            end else if (pos < 8) begin
                e_dout = p[7 - pos]; e_vld = 1'b1; e_done = 1'b0; e_state = 2'b01;
            end else begin
                e_dout = 1'b0; e_vld = 1'b0; e_done = 1'b0; e_state = 2'b10;
            end
            check($sformatf("%s c%0d f%0d dout", name, c, idx), 32'(dout),     32'(e_dout));
            check($sformatf("%s c%0d dout_vld",  name, c),      32'(dout_vld), 32'(e_vld));
            check($sformatf("%s c%0d done",      name, c),      32'(done),     32'(e_done));
            check($sformatf("%s c%0d busy",      name, c),      32'(busy),     32'd1);
            check($sformatf("%s c%0d state",     name, c),      32'(state),    32'(e_state));
            if (c == 1 && !hold) start = 1'b0;
            if (intf_at > 0 && c == intf_at) begin
                start    = 1'b1;
                pattern  = 8'hFF;
                repeat_n = 4'd5;
            end
            if (intf_at > 0 && c == intf_at + 1) start = 1'b0;
        end
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        pattern  = 8'h00;
        repeat_n = 4'd0;

        // reset held for two cycles, then released
        repeat (2) @(negedge clk);
        check_idle("rst held");
        rst = 1'b1;
        @(negedge clk);
        check_idle("rst release");
        repeat (3) @(negedge clk);
        check_idle("idle no start");

        do_job("a5x1", 8'hA5, 4'd1, 1'b0, 0);
        @(negedge clk);
        check_idle("after a5");

        do_job("81x3", 8'h81, 4'd3, 1'b0, 0);
        @(negedge clk);
        check_idle("after 81");

        do_job("aa intf", 8'hAA, 4'd1, 1'b0, 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle($sformatf("no 2nd job %0d", i));
        end

        // reset dropped after the fourth bit of F0
        @(negedge clk);
        start    = 1'b1;
        pattern  = 8'hF0;
        repeat_n = 4'd1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            check($sformatf("f0 bit%0d", c), 32'(dout), 32'd1);
        end
        #2 rst = 1'b0;
        #1;
        check_idle("rst async");
        @(negedge clk);
        check_idle("rst hold");
        rst = 1'b1;
        do_job("3c post rst", 8'h3C, 4'd1, 1'b0, 0);
        @(negedge clk);
        check_idle("after 3c");

        do_job("5a rn0", 8'h5A, 4'd0, 1'b0, 0);
        @(negedge clk);
        check_idle("after rn0");

        // start held across two jobs: exactly one idle cycle in between
        do_job("hold 1", 8'hC3, 4'd2, 1'b1, 0);
        do_job("hold 2", 8'h69, 4'd1, 1'b0, 0);
        @(negedge clk);
        check_idle("after hold");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
